// File: rtl/control_pkg.sv
// rtl/control_pkg.sv - shared state, mux-select, ALU, opcode and funct3 constants for control_unit
package control_pkg;

  // Multicycle controller states; the numeric value is exported on State for debug.
  typedef enum logic [4:0] {
    ST_FETCH       = 5'd0,
    ST_FETCH_WAIT  = 5'd1,
    ST_DECODE      = 5'd2,
    ST_R_EXEC      = 5'd3,
    ST_I_EXEC      = 5'd4,
    ST_ALU_WB      = 5'd5,
    ST_SHIFT_WB    = 5'd6,
    ST_MEM_ADDR    = 5'd7,
    ST_MEM_READ    = 5'd8,
    ST_MEM_WAIT    = 5'd9,
    ST_LOAD_WB     = 5'd10,
    ST_STORE_READ  = 5'd11,
    ST_STORE_WAIT  = 5'd12,
    ST_STORE_WRITE = 5'd13,
    ST_BRANCH      = 5'd14,
    ST_JALR_ADDR   = 5'd15,
    ST_JAL_LINK    = 5'd16,
    ST_JUMP        = 5'd17,
    ST_LUI_WB      = 5'd18,
    ST_NEXT_PC     = 5'd19,
    ST_HALT        = 5'd20
  } state_e;

  // MuxA operand select
  localparam logic [2:0] MUXA_PC      = 3'd0;
  localparam logic [2:0] MUXA_REGA    = 3'd1;

  // MuxB operand select
  localparam logic [2:0] MUXB_REGB    = 3'd0;
  localparam logic [2:0] MUXB_FOUR    = 3'd1;
  localparam logic [2:0] MUXB_SIGN    = 3'd2;
  localparam logic [2:0] MUXB_SHL     = 3'd3;

  // Register-file write-data select
  localparam logic [2:0] MEM_ALUOUT   = 3'd0;
  localparam logic [2:0] MEM_LOAD     = 3'd1;
  localparam logic [2:0] MEM_ALUEXIT  = 3'd2;
  localparam logic [2:0] MEM_SIGN     = 3'd3;
  localparam logic [2:0] MEM_LT       = 3'd4;
  localparam logic [2:0] MEM_SHIFT    = 3'd5;

  // ALU operations
  localparam logic [2:0] ALU_NOP      = 3'b000;
  localparam logic [2:0] ALU_ADD      = 3'b001;
  localparam logic [2:0] ALU_SUB      = 3'b010;
  localparam logic [2:0] ALU_AND      = 3'b011;

  // Shifter operations
  localparam logic [1:0] SH_SLL       = 2'b00;
  localparam logic [1:0] SH_SRL       = 2'b01;
  localparam logic [1:0] SH_SRA       = 2'b10;

  // Opcodes
  localparam logic [6:0] OPC_R        = 7'b0110011;
  localparam logic [6:0] OPC_I        = 7'b0010011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_LUI      = 7'b0110111;

  // funct3 values
  localparam logic [2:0] F3_ADD_SUB   = 3'b000;
  localparam logic [2:0] F3_SLL       = 3'b001;
  localparam logic [2:0] F3_SLT       = 3'b010;
  localparam logic [2:0] F3_SR        = 3'b101;
  localparam logic [2:0] F3_AND       = 3'b111;
  localparam logic [2:0] F3_SD        = 3'b011;
  localparam logic [2:0] F3_BEQ       = 3'b000;
  localparam logic [2:0] F3_BNE       = 3'b001;
  localparam logic [2:0] F3_BLT       = 3'b100;
  localparam logic [2:0] F3_BGE       = 3'b101;

  // Branch decision from funct3 and the ALU compare flags; unknown funct3 never branches.
  function automatic logic branch_taken(input logic [2:0] funct3, input logic igual,
                                        input logic menor);
    case (funct3)
      F3_BEQ:  return igual;
      F3_BNE:  return !igual;
      F3_BLT:  return menor;
      F3_BGE:  return !menor;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/control_unit.sv
// rtl/control_unit.sv - multicycle RISC-V style datapath controller (Moore FSM)
//
// Ports:
//   clk            processor clock, rising edge
//   rst            asynchronous active-low reset; forces FETCH and silences every output
//   i31_0          instruction register (opcode [6:0], funct3 [14:12], funct7 bit [30])
//   AluIgual       ALU equality flag
//   AluMenor       ALU signed less-than flag
//   PCwrite, PCWriteCond, SelMuxPC, SelMuxAddr, MemRead, MemData_Write, IRWrite,
//   RegWrite, loadRegA, loadRegB, loadRegMemData, loadRegAluOut   1-bit strobes/selects
//   SelMuxA, SelMuxB, SelMuxMem, AluOperation                      3-bit selects
//   Shift          shifter operation
//   LoadTYPE, StoreTYPE  funct3 passed to the memory during the access, else 0
//   State          current state encoding
module control_unit
  import control_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] i31_0,
  input  logic        AluIgual,
  input  logic        AluMenor,
  output logic        PCwrite,
  output logic        PCWriteCond,
  output logic        SelMuxPC,
  output logic        SelMuxAddr,
  output logic        MemRead,
  output logic        MemData_Write,
  output logic        IRWrite,
  output logic        RegWrite,
  output logic        loadRegA,
  output logic        loadRegB,
  output logic        loadRegMemData,
  output logic        loadRegAluOut,
  output logic [2:0]  SelMuxA,
  output logic [2:0]  SelMuxB,
  output logic [2:0]  SelMuxMem,
  output logic [2:0]  AluOperation,
  output logic [1:0]  Shift,
  output logic [2:0]  LoadTYPE,
  output logic [2:0]  StoreTYPE,
  output logic [4:0]  State
);

  state_e     state;
  state_e     state_next;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_b30;
  logic       is_shift_imm;
  logic       is_slt;
  logic       unused_ir_bits;

  assign opcode       = i31_0[6:0];
  assign funct3       = i31_0[14:12];
  assign funct7_b30   = i31_0[30];
  assign is_shift_imm = (funct3 == F3_SLL) || (funct3 == F3_SR);
  assign is_slt       = (opcode == OPC_R) && (funct3 == F3_SLT);

  // Register numbers and immediates are consumed by the datapath, not here.
  assign unused_ir_bits = ^{i31_0[31], i31_0[29:15], i31_0[11:7]};

  assign State = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_FETCH;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_FETCH:      state_next = ST_FETCH_WAIT;
      ST_FETCH_WAIT: state_next = ST_DECODE;
      ST_DECODE: begin
        case (opcode)
          OPC_R:      state_next = ST_R_EXEC;
          OPC_I:      state_next = is_shift_imm ? ST_SHIFT_WB : ST_I_EXEC;
          OPC_LOAD:   state_next = ST_MEM_ADDR;
          OPC_STORE:  state_next = ST_MEM_ADDR;
          OPC_BRANCH: state_next = ST_BRANCH;
          OPC_JAL:    state_next = ST_JAL_LINK;
          OPC_JALR:   state_next = ST_JALR_ADDR;
          OPC_LUI:    state_next = ST_LUI_WB;
          default:    state_next = ST_HALT;
        endcase
      end
      ST_R_EXEC:      state_next = ST_ALU_WB;
      ST_I_EXEC:      state_next = ST_ALU_WB;
      ST_ALU_WB:      state_next = ST_NEXT_PC;
      ST_SHIFT_WB:    state_next = ST_NEXT_PC;
      // Doubleword stores overwrite the whole word, so they skip the read-modify-write.
      ST_MEM_ADDR: begin
        if (opcode == OPC_LOAD)    state_next = ST_MEM_READ;
        else if (funct3 == F3_SD)  state_next = ST_STORE_WRITE;
        else                       state_next = ST_STORE_READ;
      end
      ST_MEM_READ:    state_next = ST_MEM_WAIT;
      ST_MEM_WAIT:    state_next = ST_LOAD_WB;
      ST_LOAD_WB:     state_next = ST_NEXT_PC;
      ST_STORE_READ:  state_next = ST_STORE_WAIT;
      ST_STORE_WAIT:  state_next = ST_STORE_WRITE;
      ST_STORE_WRITE: state_next = ST_NEXT_PC;
      ST_BRANCH:      state_next = branch_taken(funct3, AluIgual, AluMenor) ? ST_FETCH
                                                                            : ST_NEXT_PC;
      ST_JALR_ADDR:   state_next = ST_JAL_LINK;
      ST_JAL_LINK:    state_next = ST_JUMP;
      ST_JUMP:        state_next = ST_FETCH;
      ST_LUI_WB:      state_next = ST_NEXT_PC;
      ST_NEXT_PC:     state_next = ST_FETCH;
      ST_HALT:        state_next = ST_HALT;
      default:        state_next = ST_FETCH;
    endcase
  end

  // Reset gates the outputs combinationally so they drop the moment rst falls.
  always_comb begin
    PCwrite        = 1'b0;
    PCWriteCond    = 1'b0;
    SelMuxPC       = 1'b0;
    SelMuxAddr     = 1'b0;
    MemRead        = 1'b0;
    MemData_Write  = 1'b0;
    IRWrite        = 1'b0;
    RegWrite       = 1'b0;
    loadRegA       = 1'b0;
    loadRegB       = 1'b0;
    loadRegMemData = 1'b0;
    loadRegAluOut  = 1'b0;
    SelMuxA        = MUXA_PC;
    SelMuxB        = MUXB_REGB;
    SelMuxMem      = MEM_ALUOUT;
    AluOperation   = ALU_NOP;
    Shift          = SH_SLL;
    LoadTYPE       = 3'b000;
    StoreTYPE      = 3'b000;
    if (rst) begin
      case (state)
        ST_FETCH: begin
          SelMuxAddr = 1'b0;
          MemRead    = 1'b1;
        end
        ST_FETCH_WAIT: IRWrite = 1'b1;
        // Branch/jal target PC + (imm << 1) is precomputed while operands load.
        ST_DECODE: begin
          SelMuxA       = MUXA_PC;
          SelMuxB       = MUXB_SHL;
          AluOperation  = ALU_ADD;
          loadRegAluOut = 1'b1;
          loadRegA      = 1'b1;
          loadRegB      = 1'b1;
        end
        ST_R_EXEC: begin
          SelMuxA       = MUXA_REGA;
          SelMuxB       = MUXB_REGB;
          loadRegAluOut = 1'b1;
          case (funct3)
            F3_ADD_SUB: AluOperation = funct7_b30 ? ALU_SUB : ALU_ADD;
            F3_AND:     AluOperation = ALU_AND;
            F3_SLT:     AluOperation = ALU_SUB;
            default:    AluOperation = ALU_NOP;
          endcase
        end
        // slt writes the live AluMenor flag, so the compare operands stay selected.
        ST_ALU_WB: begin
          RegWrite = 1'b1;
          if (is_slt) begin
            SelMuxA      = MUXA_REGA;
            SelMuxB      = MUXB_REGB;
            AluOperation = ALU_SUB;
            SelMuxMem    = MEM_LT;
          end
        end
        ST_SHIFT_WB: begin
          RegWrite  = 1'b1;
          SelMuxMem = MEM_SHIFT;
          if (funct3 == F3_SLL) Shift = SH_SLL;
          else                  Shift = funct7_b30 ? SH_SRA : SH_SRL;
        end
        ST_I_EXEC, ST_MEM_ADDR, ST_JALR_ADDR: begin
          SelMuxA       = MUXA_REGA;
          SelMuxB       = MUXB_SIGN;
          AluOperation  = ALU_ADD;
          loadRegAluOut = 1'b1;
        end
        ST_MEM_READ, ST_STORE_READ: begin
          SelMuxAddr = 1'b1;
          MemRead    = 1'b1;
        end
        ST_MEM_WAIT, ST_STORE_WAIT: loadRegMemData = 1'b1;
        ST_LOAD_WB: begin
          RegWrite  = 1'b1;
          SelMuxMem = MEM_LOAD;
          LoadTYPE  = funct3;
        end
        ST_STORE_WRITE: begin
          SelMuxAddr    = 1'b1;
          MemData_Write = 1'b1;
          StoreTYPE     = funct3;
        end
        ST_BRANCH: begin
          SelMuxA      = MUXA_REGA;
          SelMuxB      = MUXB_REGB;
          AluOperation = ALU_SUB;
          PCWriteCond  = 1'b1;
          if (branch_taken(funct3, AluIgual, AluMenor)) begin
            PCwrite  = 1'b1;
            SelMuxPC = 1'b1;
          end
        end
        // Link value PC + 4 goes straight from the ALU into rd.
        ST_JAL_LINK: begin
          SelMuxA      = MUXA_PC;
          SelMuxB      = MUXB_FOUR;
          AluOperation = ALU_ADD;
          RegWrite     = 1'b1;
          SelMuxMem    = MEM_ALUEXIT;
        end
        ST_JUMP: begin
          PCwrite  = 1'b1;
          SelMuxPC = 1'b1;
        end
        ST_LUI_WB: begin
          RegWrite  = 1'b1;
          SelMuxMem = MEM_SIGN;
        end
        ST_NEXT_PC: begin
          SelMuxA      = MUXA_PC;
          SelMuxB      = MUXB_FOUR;
          AluOperation = ALU_ADD;
          PCwrite      = 1'b1;
          SelMuxPC     = 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// tb/tb_control_unit.sv - self-checking bench for control_unit
module tb_control_unit;
  import control_pkg::*;

  logic        clk;
  logic        rst;
  logic [31:0] i31_0;
  logic        AluIgual;
  logic        AluMenor;
  logic        PCwrite, PCWriteCond, SelMuxPC, SelMuxAddr, MemRead, MemData_Write, IRWrite;
  logic        RegWrite, loadRegA, loadRegB, loadRegMemData, loadRegAluOut;
  logic [2:0]  SelMuxA, SelMuxB, SelMuxMem, AluOperation, LoadTYPE, StoreTYPE;
  logic [1:0]  Shift;
  logic [4:0]  State;

  control_unit dut (
    .clk(clk), .rst(rst), .i31_0(i31_0), .AluIgual(AluIgual), .AluMenor(AluMenor),
    .PCwrite(PCwrite), .PCWriteCond(PCWriteCond), .SelMuxPC(SelMuxPC),
    .SelMuxAddr(SelMuxAddr), .MemRead(MemRead), .MemData_Write(MemData_Write),
    .IRWrite(IRWrite), .RegWrite(RegWrite), .loadRegA(loadRegA), .loadRegB(loadRegB),
    .loadRegMemData(loadRegMemData), .loadRegAluOut(loadRegAluOut),
    .SelMuxA(SelMuxA), .SelMuxB(SelMuxB), .SelMuxMem(SelMuxMem),
    .AluOperation(AluOperation), .Shift(Shift), .LoadTYPE(LoadTYPE),
    .StoreTYPE(StoreTYPE), .State(State)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       pcw, pcwc, selpc, seladdr, memrd, memwr, irw, regw, lda, ldb, ldmd, ldao;
    logic [2:0] sela, selb, selmem, aluop;
    logic [1:0] shift;
    logic [2:0] ldt, stt;
  } outs_t;

  typedef struct packed {
    state_e st;
    outs_t  o;
  } step_t;

  typedef struct {
    logic [31:0] ir;
    logic        ig;
    logic        mn;
    int          cycles;
    string       name;
  } vec_t;

  step_t exp_q[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic outs_t sample_outs();
    outs_t o;
    o.pcw = PCwrite; o.pcwc = PCWriteCond; o.selpc = SelMuxPC; o.seladdr = SelMuxAddr;
    o.memrd = MemRead; o.memwr = MemData_Write; o.irw = IRWrite; o.regw = RegWrite;
    o.lda = loadRegA; o.ldb = loadRegB; o.ldmd = loadRegMemData; o.ldao = loadRegAluOut;
    o.sela = SelMuxA; o.selb = SelMuxB; o.selmem = SelMuxMem; o.aluop = AluOperation;
    o.shift = Shift; o.ldt = LoadTYPE; o.stt = StoreTYPE;
    return o;
  endfunction

  function automatic void push(input state_e s, input outs_t o);
    step_t t;
    t.st = s;
    t.o  = o;
    exp_q.push_back(t);
  endfunction

  function automatic void push_next_pc();
    outs_t o;
    o = '0; o.selb = 3'd1; o.aluop = 3'd1; o.pcw = 1'b1;
    push(ST_NEXT_PC, o);
  endfunction

  // Reference: the whole expected state walk and per-cycle outputs of one instruction.
  function automatic void build(input logic [31:0] ir, input logic ig, input logic mn);
    logic [6:0] opc;
    logic [2:0] f3;
    logic       b30;
    logic       taken;
    outs_t      o;
    opc = ir[6:0];
    f3  = ir[14:12];
    b30 = ir[30];
    exp_q.delete();
    o = '0; o.memrd = 1'b1; push(ST_FETCH, o);
    o = '0; o.irw = 1'b1; push(ST_FETCH_WAIT, o);
    o = '0; o.selb = 3'd3; o.aluop = 3'd1; o.ldao = 1'b1; o.lda = 1'b1; o.ldb = 1'b1;
    push(ST_DECODE, o);
    if (opc == 7'h33) begin
      o = '0; o.sela = 3'd1; o.ldao = 1'b1;
      if (f3 == 3'd0)      o.aluop = b30 ? 3'd2 : 3'd1;
      else if (f3 == 3'd7) o.aluop = 3'd3;
      else if (f3 == 3'd2) o.aluop = 3'd2;
      push(ST_R_EXEC, o);
      o = '0; o.regw = 1'b1;
      if (f3 == 3'd2) begin o.sela = 3'd1; o.aluop = 3'd2; o.selmem = 3'd4; end
      push(ST_ALU_WB, o);
      push_next_pc();
    end else if (opc == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) begin
      o = '0; o.regw = 1'b1; o.selmem = 3'd5;
      o.shift = (f3 == 3'd1) ? 2'd0 : (b30 ? 2'd2 : 2'd1);
      push(ST_SHIFT_WB, o);
      push_next_pc();
    end else if (opc == 7'h13) begin
      o = '0; o.sela = 3'd1; o.selb = 3'd2; o.aluop = 3'd1; o.ldao = 1'b1;
      push(ST_I_EXEC, o);
      o = '0; o.regw = 1'b1; push(ST_ALU_WB, o);
      push_next_pc();
    end else if (opc == 7'h03 || opc == 7'h23) begin
      o = '0; o.sela = 3'd1; o.selb = 3'd2; o.aluop = 3'd1; o.ldao = 1'b1;
      push(ST_MEM_ADDR, o);
      if (opc == 7'h03) begin
        o = '0; o.seladdr = 1'b1; o.memrd = 1'b1; push(ST_MEM_READ, o);
        o = '0; o.ldmd = 1'b1; push(ST_MEM_WAIT, o);
        o = '0; o.regw = 1'b1; o.selmem = 3'd1; o.ldt = f3; push(ST_LOAD_WB, o);
      end else begin
        if (f3 != 3'd3) begin
          o = '0; o.seladdr = 1'b1; o.memrd = 1'b1; push(ST_STORE_READ, o);
          o = '0; o.ldmd = 1'b1; push(ST_STORE_WAIT, o);
        end
        o = '0; o.seladdr = 1'b1; o.memwr = 1'b1; o.stt = f3; push(ST_STORE_WRITE, o);
      end
      push_next_pc();
    end else if (opc == 7'h63) begin
      taken = (f3 == 3'd0) ? ig : (f3 == 3'd1) ? !ig : (f3 == 3'd4) ? mn :
              (f3 == 3'd5) ? !mn : 1'b0;
      o = '0; o.sela = 3'd1; o.aluop = 3'd2; o.pcwc = 1'b1; o.pcw = taken; o.selpc = taken;
      push(ST_BRANCH, o);
      if (!taken) push_next_pc();
    end else if (opc == 7'h6F || opc == 7'h67) begin
      if (opc == 7'h67) begin
        o = '0; o.sela = 3'd1; o.selb = 3'd2; o.aluop = 3'd1; o.ldao = 1'b1;
        push(ST_JALR_ADDR, o);
      end
      o = '0; o.selb = 3'd1; o.aluop = 3'd1; o.regw = 1'b1; o.selmem = 3'd2;
      push(ST_JAL_LINK, o);
      o = '0; o.pcw = 1'b1; o.selpc = 1'b1; push(ST_JUMP, o);
    end else if (opc == 7'h37) begin
      o = '0; o.regw = 1'b1; o.selmem = 3'd3; push(ST_LUI_WB, o);
      push_next_pc();
    end else begin
      push(ST_HALT, '0);
    end
  endfunction

  // Called half a cycle into a FETCH; returns at the negedge of the next FETCH.
  task automatic run_instr(input logic [31:0] ir, input logic ig, input logic mn,
                           input int exp_cyc, input string nm);
    int cyc;
    build(ir, ig, mn);
    i31_0 = ir; AluIgual = ig; AluMenor = mn;
    #1;
    cyc = 0;
    forever begin
      if (cyc > 0) begin
        @(negedge clk);
        if (State == 5'(ST_FETCH)) break;
      end
      if (cyc >= 40) begin
        chk($sformatf("%s timeout", nm), 32'(cyc), 32'(exp_q.size()));
        break;
      end
      if (cyc < exp_q.size()) begin
        chk($sformatf("%s step %0d state", nm, cyc), 32'(State), 32'(exp_q[cyc].st));
        chk($sformatf("%s step %0d outs", nm, cyc), sample_outs(), exp_q[cyc].o);
      end else begin
        chk($sformatf("%s extra step %0d", nm, cyc), 32'(State), 32'(ST_FETCH));
      end
      cyc++;
    end
    chk($sformatf("%s cycles vs model", nm), 32'(cyc), 32'(exp_q.size()));
    if (exp_cyc > 0) chk($sformatf("%s cycles", nm), 32'(cyc), 32'(exp_cyc));
  endtask

  logic [6:0] opcs [8] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37};

  initial begin
    logic [31:0] rnd;
    logic [31:0] ir;
    int          n;

    rst = 1'b0; i31_0 = 32'h0020_8033; AluIgual = 1'b0; AluMenor = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset state", 32'(State), 32'(ST_FETCH));
    chk("reset outs", sample_outs(), '0);
    rst = 1'b1;

    vecs.push_back('{32'h0020_8033, 1'b0, 1'b0, 6, "add"});
    vecs.push_back('{32'h4020_8033, 1'b0, 1'b0, 6, "sub"});
    vecs.push_back('{32'h0020_F033, 1'b0, 1'b0, 6, "and"});
    vecs.push_back('{32'h0020_A033, 1'b0, 1'b1, 6, "slt"});
    vecs.push_back('{32'h0010_8093, 1'b0, 1'b0, 6, "addi"});
    vecs.push_back('{32'h0010_9093, 1'b0, 1'b0, 5, "slli"});
    vecs.push_back('{32'h4010_D093, 1'b0, 1'b0, 5, "srai"});
    vecs.push_back('{32'h0010_D093, 1'b0, 1'b0, 5, "srli"});
    vecs.push_back('{32'h0000_B083, 1'b0, 1'b0, 8, "ld"});
    vecs.push_back('{32'h0011_2023, 1'b0, 1'b0, 8, "sw"});
    vecs.push_back('{32'h0011_3023, 1'b0, 1'b0, 6, "sd"});
    vecs.push_back('{32'h0020_8463, 1'b1, 1'b0, 4, "beq taken"});
    vecs.push_back('{32'h0020_8463, 1'b0, 1'b0, 5, "beq not taken"});
    vecs.push_back('{32'h0020_9463, 1'b0, 1'b1, 4, "bne taken"});
    vecs.push_back('{32'h0020_C463, 1'b0, 1'b1, 4, "blt taken"});
    vecs.push_back('{32'h0020_D463, 1'b0, 1'b1, 5, "bge not taken"});
    vecs.push_back('{32'h0080_00EF, 1'b0, 1'b0, 5, "jal"});
    vecs.push_back('{32'h0000_80E7, 1'b0, 1'b0, 6, "jalr"});
    vecs.push_back('{32'h0000_10B7, 1'b0, 1'b0, 5, "lui"});

    foreach (vecs[i]) run_instr(vecs[i].ir, vecs[i].ig, vecs[i].mn, vecs[i].cycles, vecs[i].name);

    for (int k = 0; k < 60; k++) begin
      rnd = $urandom();
      ir  = {rnd[31:7], opcs[$urandom_range(0, 7)]};
      run_instr(ir, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 0,
                $sformatf("rand%0d ir=%08h", k, ir));
    end

    // Illegal opcode: parks in HALT with every output low until reset.
    build(32'hFFFF_FFFF, 1'b0, 1'b0);
    i31_0 = 32'hFFFF_FFFF;
    #1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("halt step %0d state", k), 32'(State), 32'(exp_q[k].st));
      chk($sformatf("halt step %0d outs", k), sample_outs(), exp_q[k].o);
    end
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("halt hold %0d state", k), 32'(State), 32'(ST_HALT));
      chk($sformatf("halt hold %0d outs", k), sample_outs(), '0);
    end
    #2 rst = 1'b0;
    #1;
    chk("halt reset state", 32'(State), 32'(ST_FETCH));
    chk("halt reset outs", sample_outs(), '0);
    @(negedge clk);
    chk("halt reset held outs", sample_outs(), '0);
    rst = 1'b1;
    run_instr(32'h0020_8033, 1'b0, 1'b0, 6, "add after halt");

    // Reset dropped in the middle of LOAD_WB.
    i31_0 = 32'h0000_B083;
    n = 0;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (State == 5'(ST_LOAD_WB)) break;
    end
    chk("cycles to LOAD_WB", 32'(n), 32'd6);
    chk("LOAD_WB RegWrite", 32'(RegWrite), 32'd1);
    chk("LOAD_WB LoadTYPE", 32'(LoadTYPE), 32'd3);
    #2 rst = 1'b0;
    #1;
    chk("async reset state", 32'(State), 32'(ST_FETCH));
    chk("async reset outs", sample_outs(), '0);
    @(posedge clk);
    #1;
    chk("reset held state", 32'(State), 32'(ST_FETCH));
    chk("reset held outs", sample_outs(), '0);
    @(negedge clk);
    rst = 1'b1;
    run_instr(32'h0000_B083, 1'b0, 1'b0, 8, "ld after reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/control_unit.md
CONTROL_UNIT -- requirements
Module: control_unit

Interface
REQ-001 clk  in  1  processor clock, all state changes on rising edge.
REQ-002 rst  in  1  reset; one clock, reset asynchronous and active-low.
REQ-003 i31_0  in  32  instruction register contents; opcode [6:0], funct3 [14:12], funct7 bit [30].
REQ-004 AluIgual  in  1  ALU equality flag for current MuxA/MuxB operands.
REQ-005 AluMenor  in  1  ALU signed less-than flag for current operands.
REQ-006 PCwrite  out  1  load PC from MuxPC.
REQ-007 PCWriteCond  out  1  high only in BRANCH state (trace/debug).
REQ-008 SelMuxPC  out  1  0=AluExit, 1=AluOut.
REQ-009 SelMuxAddr  out  1  memory address: 0=PC, 1=AluOut.
REQ-010 MemRead  out  1  memory read strobe.
REQ-011 MemData_Write  out  1  memory write strobe.
REQ-012 IRWrite  out  1  load instruction register from MemExit.
REQ-013 RegWrite  out  1  register-file write of rd.
REQ-014 loadRegA / loadRegB  out  1 each  load operand registers.
REQ-015 loadRegMemData  out  1  load memory-data register.
REQ-016 loadRegAluOut  out  1  load AluOut register.
REQ-017 SelMuxA  out  3  0=PC, 1=RegA.
REQ-018 SelMuxB  out  3  0=RegB, 1=const 4, 2=SignExit, 3=ShiftLeftExit.
REQ-019 SelMuxMem  out  3  rd data: 0=AluOut, 1=LoadResult, 2=AluExit, 3=SignExit, 4=zero-extended AluMenor, 5=ShiftExit.
REQ-020 AluOperation  out  3  001 add, 010 sub, 011 and; 000 otherwise.
REQ-021 Shift  out  2  00 sll, 01 srl, 10 sra.
REQ-022 LoadTYPE / StoreTYPE  out  3 each  funct3 forwarded when the access is active, else 000.
REQ-023 State  out  5  current state encoding (debug).

Function
REQ-024 Moore outputs from state plus decoded IR; every output not named for a state SHALL be 0.
REQ-025 FETCH: SelMuxAddr=0, MemRead -> FETCH_WAIT: IRWrite -> DECODE.
REQ-026 DECODE: A=PC, B=ShiftLeftExit, add, loadRegAluOut, loadRegA, loadRegB; dispatch on opcode.
REQ-027 0110011 (add/sub/and/slt by funct3/funct7) -> R_EXEC (A=1, B=0, op, loadRegAluOut) -> ALU_WB (RegWrite, SelMuxMem 0; for slt selects held, sub, SelMuxMem 4) -> NEXT_PC.
REQ-028 0010011 addi -> I_EXEC (A=1, B=2, add, loadRegAluOut) -> ALU_WB; funct3 001/101 -> SHIFT_WB (Shift from funct3/bit30, RegWrite, SelMuxMem 5) -> NEXT_PC.
REQ-029 0000011 -> MEM_ADDR (A=1, B=2, add, loadRegAluOut) -> MEM_READ (SelMuxAddr 1, MemRead) -> MEM_WAIT (loadRegMemData) -> LOAD_WB (RegWrite, SelMuxMem 1, LoadTYPE) -> NEXT_PC.
REQ-030 0100011: MEM_ADDR -> sd (funct3 011) STORE_WRITE directly; sb/sh/sw via STORE_READ -> STORE_WAIT (read-modify-write) -> STORE_WRITE (SelMuxAddr 1, MemData_Write, StoreTYPE) -> NEXT_PC.
REQ-031 1100011 -> BRANCH (A=1, B=0, sub, PCWriteCond); taken per funct3 000 Igual, 001 !Igual, 100 Menor, 101 !Menor: PCwrite, SelMuxPC 1 -> FETCH; else -> NEXT_PC.
REQ-032 1101111 jal -> JAL_LINK; 1100111 jalr -> JALR_ADDR (A=1, B=2, add, loadRegAluOut) -> JAL_LINK; JAL_LINK (A=0, B=1, add, RegWrite, SelMuxMem 2) -> JUMP (PCwrite, SelMuxPC 1) -> FETCH.
REQ-033 0110111 lui -> LUI_WB (RegWrite, SelMuxMem 3) -> NEXT_PC.
REQ-034 NEXT_PC: A=0, B=1, add, PCwrite, SelMuxPC 0 -> FETCH.
REQ-035 Any other opcode (incl. 1110011) -> HALT; HALT holds all outputs 0 until reset.
REQ-036 Cycle counts: R/addi/sd 6, load and partial store 8, branch taken 4, not taken 5, jal 5, jalr 6, lui/shift 5.

Reset
REQ-037 rst low SHALL immediately force FETCH and all outputs 0 except State, mid-instruction included; first FETCH on first rising edge after rst rises.

Structure
REQ-038 State enum, mux-select, ALU, opcode and funct3 constants in shared package control_pkg; single module, no sub-module.

Verification
REQ-039 Reset release, IR=0x00208033 (add) -> states FETCH,FETCH_WAIT,DECODE,R_EXEC,ALU_WB,NEXT_PC; RegWrite once, SelMuxMem 0.
REQ-040 IR=0x0000B083 (ld) -> MemRead in FETCH and MEM_READ, LoadTYPE 011 in LOAD_WB, 8 cycles.
REQ-041 IR=0x00112023 (sw) -> STORE_READ/STORE_WAIT visited, MemData_Write one cycle with StoreTYPE 010; sd 0x00113023 skips them.
REQ-042 beq IR=0x00208463 with AluIgual=1 -> PCwrite+SelMuxPC 1 in BRANCH, 4 cycles; AluIgual=0 -> NEXT_PC, 5 cycles.
REQ-043 IR=0xFFFFFFFF -> HALT, outputs 0 for 20 cycles; rst pulsed low mid-LOAD_WB -> outputs 0 asynchronously, restart at FETCH.
